// File: rtl/buzz_pkg.sv
// Shared types and constants for the buzzer scheduler: requester IDs,
// sequencer states and tone-select encoding.
package buzz_pkg;

  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_KEY   = 2'd1,
    SRC_CHIME = 2'd2,
    SRC_ALARM = 2'd3
  } src_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_e;

  localparam logic TONE_LO = 1'b0;
  localparam logic TONE_HI = 1'b1;

endpackage

// File: rtl/buzzer_sched_tone_gen.sv
// Square-wave tone generator: half-period counter plus toggle flop.
// A synchronous clear forces tone=1 so every ON interval starts high.
module tone_gen
  import buzz_pkg::*;
#(
  parameter int HALF_LO = 25000,
  parameter int HALF_HI = 12500
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic sel_hi,
  output logic tone
);

  localparam int HMAX = (HALF_LO > HALF_HI) ? HALF_LO : HALF_HI;
  localparam int CW   = (HMAX > 1) ? $clog2(HMAX + 1) : 1;

  logic [CW-1:0] cnt_q;
  logic          tone_q;
  logic [CW-1:0] half_m1_s;

  assign half_m1_s = (sel_hi == TONE_HI) ? CW'(HALF_HI - 1) : CW'(HALF_LO - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
    end else if (clr) begin
      cnt_q  <= '0;
      tone_q <= 1'b1;
    end else if (en) begin
      if (cnt_q == half_m1_s) begin
        cnt_q  <= '0;
        tone_q <= ~tone_q;
      end else begin
        cnt_q  <= cnt_q + CW'(1);
      end
    end else begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
    end
  end

  assign tone = tone_q;

endmodule

// File: rtl/buzzer_sched.sv
// Fixed-priority buzzer scheduler (alarm > chime > key) with ms-exact beep
// sequencing. Optional BUZZ_MUTE_EN adds a mute input gating the pin.
module buzzer_sched
  import buzz_pkg::*;
#(
  parameter int MS_CYC    = 50000,
  parameter int HALF_LO   = 25000,
  parameter int HALF_HI   = 12500,
  parameter int BEEP_MS   = 200,
  parameter int GAP_MS    = 800,
  parameter int LONG_MS   = 1000,
  parameter int CHIME_N   = 2,
  parameter int KEY_MS    = 30,
  parameter int ALARM_MAX = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alarm_req,
  input  logic       alarm_stop,
  input  logic       chime_req,
  input  logic       key_req,
`ifdef BUZZ_MUTE_EN
  input  logic       mute,
`endif
  output logic       buzzer,
  output logic       busy,
  output logic [1:0] active_src,
  output logic       done,
  output logic       key_drop
);

  localparam int CW = (MS_CYC > 1) ? $clog2(MS_CYC) : 1;

  state_e        state_q, state_d;
  src_e          src_q, src_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [15:0]   ms_q, ms_d;
  logic [15:0]   dur_q, dur_d;
  logic [7:0]    beep_idx_q, beep_idx_d;
  logic          tone_sel_q, tone_sel_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          key_drop_q, key_drop_d;
  logic          pending_q, pending_d;
  logic          silenced_q, silenced_d;

  logic last_s, alarm_go_s, alarm_kill_s, alarm_end_s;
  logic chime_want_s, chime_start_s, key_start_s, pat_end_s, iv_start_s;
  logic tone_s;

  assign last_s       = (cyc_q == CW'(MS_CYC - 1)) && (ms_q == (dur_q - 16'd1));
  assign alarm_go_s   = alarm_req && !silenced_q && (src_q != SRC_ALARM);
  assign alarm_kill_s = (src_q == SRC_ALARM) && (alarm_stop || !alarm_req);
  // A chime_req during a running chime is merged into it.
  assign chime_want_s = pending_q || (chime_req && (src_q != SRC_CHIME));

  always_comb begin
    state_d       = state_q;
    src_d         = src_q;
    dur_d         = dur_q;
    beep_idx_d    = beep_idx_q;
    tone_sel_d    = tone_sel_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    iv_start_s    = 1'b0;
    alarm_end_s   = 1'b0;
    chime_start_s = 1'b0;
    key_start_s   = 1'b0;
    pat_end_s     = 1'b0;

    if (alarm_go_s) begin
      done_d     = busy_q;
      state_d    = ST_ON;
      src_d      = SRC_ALARM;
      beep_idx_d = 8'd0;
      tone_sel_d = TONE_HI;
      dur_d      = 16'(BEEP_MS);
      busy_d     = 1'b1;
      iv_start_s = 1'b1;
    end else if (alarm_kill_s) begin
      alarm_end_s = 1'b1;
      pat_end_s   = 1'b1;
    end else if ((state_q != ST_IDLE) && last_s) begin
      case (src_q)
        SRC_ALARM: begin
          if (state_q == ST_ON) begin
            if (beep_idx_q == 8'(ALARM_MAX - 1)) begin
              alarm_end_s = 1'b1;
              pat_end_s   = 1'b1;
            end else begin
              state_d    = ST_OFF;
              dur_d      = 16'(GAP_MS);
              iv_start_s = 1'b1;
            end
          end else begin
            state_d    = ST_ON;
            beep_idx_d = beep_idx_q + 8'd1;
            dur_d      = 16'(BEEP_MS);
            iv_start_s = 1'b1;
          end
        end
        SRC_CHIME: begin
          if (state_q == ST_ON) begin
            if (beep_idx_q == 8'(CHIME_N)) begin
              pat_end_s = 1'b1;
            end else begin
              state_d    = ST_OFF;
              dur_d      = 16'(GAP_MS);
              iv_start_s = 1'b1;
            end
          end else begin
            state_d    = ST_ON;
            beep_idx_d = beep_idx_q + 8'd1;
            iv_start_s = 1'b1;
            if ((beep_idx_q + 8'd1) == 8'(CHIME_N)) begin
              tone_sel_d = TONE_HI;
              dur_d      = 16'(LONG_MS);
            end else begin
              tone_sel_d = TONE_LO;
              dur_d      = 16'(BEEP_MS);
            end
          end
        end
        SRC_KEY: pat_end_s = 1'b1;
        default: pat_end_s = 1'b1;
      endcase
    end else if (state_q == ST_IDLE) begin
      // src_q==SRC_CHIME in IDLE marks the one-cycle handoff after a pattern.
      if ((src_q == SRC_CHIME) || chime_want_s) begin
        state_d       = ST_ON;
        src_d         = SRC_CHIME;
        beep_idx_d    = 8'd0;
        tone_sel_d    = (CHIME_N == 0) ? TONE_HI : TONE_LO;
        dur_d         = (CHIME_N == 0) ? 16'(LONG_MS) : 16'(BEEP_MS);
        busy_d        = 1'b1;
        iv_start_s    = 1'b1;
        chime_start_s = 1'b1;
      end else if (key_req) begin
        state_d     = ST_ON;
        src_d       = SRC_KEY;
        beep_idx_d  = 8'd0;
        tone_sel_d  = TONE_HI;
        dur_d       = 16'(KEY_MS);
        busy_d      = 1'b1;
        iv_start_s  = 1'b1;
        key_start_s = 1'b1;
      end else begin
        src_d  = SRC_NONE;
        busy_d = 1'b0;
      end
    end else begin
      state_d = state_q;
    end

    if (pat_end_s) begin
      done_d  = 1'b1;
      state_d = ST_IDLE;
      if (chime_want_s) begin
        src_d  = SRC_CHIME;
        busy_d = 1'b1;
      end else begin
        src_d  = SRC_NONE;
        busy_d = 1'b0;
      end
    end else begin
      busy_d = busy_d;
    end
  end

  always_comb begin
    key_drop_d = key_req && !key_start_s;
    if (chime_start_s || (pat_end_s && chime_want_s)) begin
      pending_d = 1'b0;
    end else begin
      pending_d = chime_want_s;
    end
    if (!alarm_req) begin
      silenced_d = 1'b0;
    end else if (alarm_end_s) begin
      silenced_d = 1'b1;
    end else begin
      silenced_d = silenced_q;
    end
    if (iv_start_s || (state_d == ST_IDLE)) begin
      cyc_d = '0;
      ms_d  = 16'd0;
    end else if (cyc_q == CW'(MS_CYC - 1)) begin
      cyc_d = '0;
      ms_d  = ms_q + 16'd1;
    end else begin
      cyc_d = cyc_q + CW'(1);
      ms_d  = ms_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      src_q      <= SRC_NONE;
      cyc_q      <= '0;
      ms_q       <= 16'd0;
      dur_q      <= 16'd0;
      beep_idx_q <= 8'd0;
      tone_sel_q <= TONE_LO;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      key_drop_q <= 1'b0;
      pending_q  <= 1'b0;
      silenced_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      cyc_q      <= cyc_d;
      ms_q       <= ms_d;
      dur_q      <= dur_d;
      beep_idx_q <= beep_idx_d;
      tone_sel_q <= tone_sel_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      key_drop_q <= key_drop_d;
      pending_q  <= pending_d;
      silenced_q <= silenced_d;
    end
  end

  tone_gen #(
    .HALF_LO (HALF_LO),
    .HALF_HI (HALF_HI)
  ) u_tone (
    .clk    (clk),
    .rst    (rst),
    .clr    (iv_start_s && (state_d == ST_ON)),
    .en     (state_d == ST_ON),
    .sel_hi (tone_sel_q),
    .tone   (tone_s)
  );

`ifdef BUZZ_MUTE_EN
  assign buzzer = tone_s & ~mute;
`else
  assign buzzer = tone_s;
`endif
  assign busy       = busy_q;
  assign active_src = src_q;
  assign done       = done_q;
  assign key_drop   = key_drop_q;

endmodule

// File: tb/tb_buzzer_sched.sv
// Directed bench for buzzer_sched using the small-parameter timing set.
module tb_buzzer_sched;

  logic       clk = 1'b0;
  logic       rst, alarm_req, alarm_stop, chime_req, key_req;
`ifdef BUZZ_MUTE_EN
  logic       mute;
`endif
  logic       buzzer, busy, done, key_drop;
  logic [1:0] active_src;
  int         n_chk = 0;
  int         n_bad = 0;

  buzzer_sched #(
    .MS_CYC(10), .HALF_LO(4), .HALF_HI(2), .BEEP_MS(3), .GAP_MS(2),
    .LONG_MS(6), .CHIME_N(2), .KEY_MS(1), .ALARM_MAX(3)
  ) dut (
    .clk(clk), .rst(rst), .alarm_req(alarm_req), .alarm_stop(alarm_stop),
    .chime_req(chime_req), .key_req(key_req),
`ifdef BUZZ_MUTE_EN
    .mute(mute),
`endif
    .buzzer(buzzer), .busy(busy), .active_src(active_src), .done(done),
    .key_drop(key_drop)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // n busy cycles of source src; half=0 means silent, else tone phase from off
  task automatic seg(input string tag, input int n, input int half, input int off,
                     input logic [1:0] src);
    for (int i = 0; i < n; i++) begin
      int eb;
      eb = (half == 0) ? 0 : ((((i + off) / half) % 2) == 0 ? 1 : 0);
      chk({tag, "_buz"}, buzzer, eb);
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_src"}, active_src, src);
      chk({tag, "_done"}, done, 0);
      tick();
    end
  endtask

  task automatic fin(input string tag);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_src"}, active_src, 0);
    chk({tag, "_buz"}, buzzer, 0);
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_buz"}, buzzer, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_src"}, active_src, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_kdrop"}, key_drop, 0);
  endtask

  initial begin
    rst = 1'b1; alarm_req = 1'b0; alarm_stop = 1'b0; chime_req = 1'b0; key_req = 1'b0;
`ifdef BUZZ_MUTE_EN
    mute = 1'b0;
`endif
    tick(); tick();
    all_zero("rst");
    rst = 1'b0;
    tick();
    all_zero("idle");

    // chime: 30 lo, 20 off, 30 lo, 20 off, 60 hi, done at 161
    chime_req = 1'b1; tick(); chime_req = 1'b0;
    seg("ch_lo1", 30, 4, 0, 2'd2);
    seg("ch_gap1", 20, 0, 0, 2'd2);
    seg("ch_lo2", 30, 4, 0, 2'd2);
    seg("ch_gap2", 20, 0, 0, 2'd2);
    seg("ch_hi", 60, 2, 0, 2'd2);
    fin("ch_end");
    tick();
    chk("ch_done_once", done, 0);

    // key click with a dropped second key at cycle 5
    key_req = 1'b1; tick(); key_req = 1'b0;
    seg("k_a", 4, 2, 0, 2'd1);
    key_req = 1'b1;
    seg("k_b", 1, 2, 4, 2'd1);
    key_req = 1'b0;
    chk("k_drop", key_drop, 1);
    seg("k_c", 5, 2, 5, 2'd1);
    fin("k_end");
    chk("k_drop_clr", key_drop, 0);
    tick();

    // alarm held high: three beeps then silenced
    alarm_req = 1'b1; tick();
    seg("al_on1", 30, 2, 0, 2'd3);
    seg("al_gap1", 20, 0, 0, 2'd3);
    seg("al_on2", 30, 2, 0, 2'd3);
    seg("al_gap2", 20, 0, 0, 2'd3);
    seg("al_on3", 30, 2, 0, 2'd3);
    fin("al_end");
    for (int i = 0; i < 25; i++) begin
      tick();
      chk("al_silent_busy", busy, 0);
      chk("al_silent_buz", buzzer, 0);
    end
    alarm_req = 1'b0; tick();
    alarm_req = 1'b1; tick();
    chk("al_rearm_busy", busy, 1);
    chk("al_rearm_src", active_src, 3);
    chk("al_rearm_buz", buzzer, 1);
    alarm_req = 1'b0; tick();
    fin("al_fall");
    tick();

    // alarm preempts a chime during its second beep
    chime_req = 1'b1; tick(); chime_req = 1'b0;
    seg("pre_lo1", 30, 4, 0, 2'd2);
    seg("pre_gap1", 20, 0, 0, 2'd2);
    seg("pre_lo2", 9, 4, 0, 2'd2);
    alarm_req = 1'b1;
    seg("pre_lo2b", 1, 4, 9, 2'd2);
    chk("pre_done", done, 1);
    chk("pre_busy", busy, 1);
    chk("pre_src", active_src, 3);
    chk("pre_buz", buzzer, 1);
    alarm_stop = 1'b1; tick(); alarm_stop = 1'b0;
    fin("pre_stop");
    alarm_req = 1'b0; tick(); tick();
    chk("pre_no_resume", busy, 0);

    // pending chime handed over when the alarm is stopped
    alarm_req = 1'b1; tick();
    seg("pd_al_a", 4, 2, 0, 2'd3);
    chime_req = 1'b1;
    seg("pd_al_b", 1, 2, 4, 2'd3);
    chime_req = 1'b0;
    seg("pd_al_c", 5, 2, 5, 2'd3);
    alarm_stop = 1'b1;
    seg("pd_al_d", 1, 2, 10, 2'd3);
    alarm_stop = 1'b0;
    chk("pd_hand_done", done, 1);
    chk("pd_hand_busy", busy, 1);
    chk("pd_hand_src", active_src, 2);
    chk("pd_hand_buz", buzzer, 0);
    alarm_req = 1'b0;
    tick();
    seg("pd_ch_a", 8, 4, 0, 2'd2);
    alarm_stop = 1'b1;
    seg("pd_ign", 1, 4, 8, 2'd2);
    alarm_stop = 1'b0;
    seg("pd_ch_b", 3, 4, 9, 2'd2);

    // reset in the middle of an ON interval
    rst = 1'b1; tick(); rst = 1'b0;
    all_zero("mid_rst");
    tick(); tick();
    chk("mid_rst_stay", busy, 0);

    // simultaneous requests from idle
    chime_req = 1'b1; key_req = 1'b1; tick(); chime_req = 1'b0; key_req = 1'b0;
    chk("sim_ck_src", active_src, 2);
    chk("sim_ck_drop", key_drop, 1);
    chk("sim_ck_buz", buzzer, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    alarm_req = 1'b1; chime_req = 1'b1; key_req = 1'b1; tick();
    chime_req = 1'b0; key_req = 1'b0;
    chk("sim_all_src", active_src, 3);
    chk("sim_all_drop", key_drop, 1);
    alarm_req = 1'b0; tick();
    chk("sim_all_done", done, 1);
    chk("sim_all_busy", busy, 1);
    chk("sim_all_src2", active_src, 2);
    tick();
    chk("sim_all_chime", buzzer, 1);
    rst = 1'b1; tick(); rst = 1'b0; tick();

`ifdef BUZZ_MUTE_EN
    // muted chime keeps identical sequencing with a silent pin
    mute = 1'b1;
    chime_req = 1'b1; tick(); chime_req = 1'b0;
    seg("mu_lo1", 30, 0, 0, 2'd2);
    seg("mu_gap1", 20, 0, 0, 2'd2);
    seg("mu_lo2", 30, 0, 0, 2'd2);
    seg("mu_gap2", 20, 0, 0, 2'd2);
    seg("mu_hi", 60, 0, 0, 2'd2);
    fin("mu_end");
    mute = 1'b0;
    tick();
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/buzzer_sched.md
# buzzer_sched

Scheduler that owns the single piezo buzzer output of the digital clock and shares it between three requesters: the alarm-clock match, the hourly chime and key-press feedback. It arbitrates by fixed priority, sequences each requester's beep pattern with exact millisecond timing, and generates both tone frequencies internally. It sits between the time/alarm comparison logic and the buzzer pin, replacing direct tone muxing in those blocks.

## Interface
- MS_CYC, 50000 — clock cycles per millisecond
- HALF_LO, 25000 — half-period of the low tone, in cycles
- HALF_HI, 12500 — half-period of the high tone, in cycles
- BEEP_MS, 200 — short beep on-time
- GAP_MS, 800 — silence between beeps
- LONG_MS, 1000 — final chime beep on-time
- CHIME_N, 2 — low beeps before the high chime beep
- KEY_MS, 30 — key-click on-time
- ALARM_MAX, 60 — alarm beeps before auto-stop
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- alarm_req  in  1  level; alarm time matched
- alarm_stop  in  1  pulse; user silences the alarm
- chime_req  in  1  pulse; top of the hour
- key_req  in  1  pulse; key pressed
- buzzer  out  1  tone output to the pin
- busy  out  1  a pattern is running
- active_src  out  2  0 none, 1 key, 2 chime, 3 alarm
- done  out  1  one-cycle pulse when a pattern completes or is aborted
- key_drop  out  1  one-cycle pulse when a key request is discarded

## Operation
- Reset: buzzer=0, busy=0, active_src=0, done=0, key_drop=0, FSM IDLE, all counters 0, chime pending flag clear.
- FSM states: IDLE, ON, OFF. The pattern registers are beep_idx, tone_sel and on/off duration.
- Priority: alarm > chime > key.
- Alarm: while alarm_req=1 and not silenced, it repeats a high tone for BEEP_MS followed by GAP_MS of silence. It ends on alarm_stop, on alarm_req falling, or after ALARM_MAX beeps. After it ends, the alarm stays silenced until alarm_req has been low for at least one cycle.
- Chime: CHIME_N low-tone beeps of BEEP_MS, each followed by GAP_MS, then one high-tone beep of LONG_MS with no trailing gap.
- Key: one high-tone beep of KEY_MS.
- Preemption: an alarm arriving during a chime or key pattern aborts it.
  - done pulses for the aborted pattern.
  - The alarm starts on the next cycle.
  - An aborted chime is not resumed.
- Pending requests:
  - chime_req arriving during an alarm sets the pending flag.
  - The chime starts the cycle after the alarm ends. A second chime_req while pending is merged.
  - key_req arriving while busy is discarded and key_drop pulses.
- Simultaneous requests in IDLE: the highest priority wins. A simultaneous chime is latched as pending. A simultaneous key is dropped.
- Tone generator: cleared at the start of every ON interval so that buzzer=1 in the first ON cycle. It toggles every HALF_x cycles. buzzer=0 throughout OFF and IDLE.
- Counters: the cycle counter is sized clog2(MS_CYC) and the ms counter is 16 bits. Both are cleared at every interval start, so intervals are exact multiples of MS_CYC. No wrap-around is possible within legal parameters.
- alarm_stop while not in an alarm is ignored.

## Timing
- A request sampled at edge N produces its first ON cycle (buzzer=1, busy=1, active_src valid) at N+1.
- An interval of D ms lasts exactly D*MS_CYC cycles.
- done pulses in the cycle after the last interval. In that same cycle busy=0 and active_src=0, unless a pending chime starts then: in that case busy stays 1 and active_src=2.
- alarm_stop sampled at edge N gives buzzer=0 and a done pulse at N+1.
- Reset asserted mid-pattern returns every output to its reset value at the next edge. The pending flag is lost.

## Configuration
- BUZZ_MUTE_EN defined: adds input `mute` (in, 1). While mute=1, buzzer is forced to 0 but all sequencing, busy, active_src and done behave unchanged.
- BUZZ_MUTE_EN undefined: there is no mute port and buzzer is driven directly from the tone generator.

## Structure
- Package buzz_pkg holds:
  - the source enum (SRC_NONE, SRC_KEY, SRC_CHIME, SRC_ALARM);
  - the FSM state enum;
  - the tone-select constants.
- Sub-module tone_gen has:
  - parameters HALF_LO and HALF_HI;
  - inputs clk, rst, clr, en and sel_hi;
  - output tone.
  It is a half-period counter plus a toggle flop with synchronous clear to tone=1.

## Test plan
All scenarios use MS_CYC=10, HALF_LO=4, HALF_HI=2, BEEP_MS=3, GAP_MS=2, LONG_MS=6, CHIME_N=2, KEY_MS=1, ALARM_MAX=3.
- chime_req at cycle 0 -> sequence of 30 cycles of low tone (4-cycle half-period), 20 off, 30 low, 20 off, 60 high (2-cycle half-period); done at cycle 161.
- key_req at cycle 0 -> 10 cycles of high tone from cycle 1; done at cycle 11. A second key_req at cycle 5 -> key_drop at cycle 6.
- alarm_req held high -> exactly 3 high beeps of 30 cycles with 20-cycle gaps, then done. No further beeps until alarm_req falls and rises again.
- Alarm mid-way through a chime's second beep -> chime aborted with a done pulse, alarm ON in the next cycle with active_src=3.
- chime_req during an alarm, then alarm_stop -> buzzer=0 and done on the cycle after alarm_stop, with the chime starting in that same cycle (active_src=2).
- Reset asserted during ON -> all outputs 0 on the next cycle. With BUZZ_MUTE_EN and mute=1, a chime keeps buzzer=0 while busy timing is identical.
